// File: rtl/line_seq_pkg.sv
// Shared types and constants for the line scan sequencer.
//   - seq_state_e : sequencer states
//   - LINE_W      : width of the line counter / line index
//   - DEF_*       : default frame timing
//   - timer_width : bits needed by the shared interval timer
package line_seq_pkg;

  localparam int unsigned LINE_W = 12;

  localparam int unsigned DEF_ACTIVE_LINES = 480;
  localparam int unsigned DEF_HBLANK_CYC   = 16;
  localparam int unsigned DEF_VBLANK_CYC   = 1024;
  localparam int unsigned DEF_MAX_LINE_CYC = 4200;
  localparam int unsigned DEF_CONTINUOUS   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } seq_state_e;

  // Timer must count 0..max(h, v, m)-1.
  function automatic int unsigned timer_width(input int unsigned h,
                                              input int unsigned v,
                                              input int unsigned m);
    int unsigned mx;
    mx = (h > v) ? h : v;
    mx = (m > mx) ? m : mx;
    return (mx < 32'd2) ? 32'd1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/line_scan_sequencer_if.sv
// Control/status bundle between the line scan sequencer and its environment.
//   start, stop, test_mode : frame control requests
//   end_line               : end-of-line pulse from the 12-bit line counter
//   cnt_enb, cnt_test      : drive to the line counter
//   line_idx, hblank, vblank, busy, frame_done, err : sequencer status
// slave  = sequencer side, master = controller/counter side.
interface line_scan_sequencer_if;
  import line_seq_pkg::*;

  logic              start;
  logic              stop;
  logic              test_mode;
  logic              end_line;
  logic              cnt_enb;
  logic              cnt_test;
  logic [LINE_W-1:0] line_idx;
  logic              hblank;
  logic              vblank;
  logic              busy;
  logic              frame_done;
  logic              err;

  modport slave (
    input  start, stop, test_mode, end_line,
    output cnt_enb, cnt_test, line_idx, hblank, vblank, busy, frame_done, err
  );

  modport master (
    output start, stop, test_mode, end_line,
    input  cnt_enb, cnt_test, line_idx, hblank, vblank, busy, frame_done, err
  );

endinterface

// File: rtl/seq_timer.sv
// Loadable up-counter shared by the blanking and watchdog intervals.
//   clk, rst      : clock, async active-high reset
//   clr_i         : synchronous clear (highest priority)
//   load_i        : load load_val_i
//   en_i          : increment by one
//   limit_i       : runtime terminal value
//   cnt_o         : current count (registered)
//   at_limit_c_o  : combinational cnt_o == limit_i
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         at_limit_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign at_limit_c_o = (cnt_q == limit_i);

endmodule

// File: rtl/line_scan_sequencer.sv
// Frame sequencer for the 12-bit line counter: enables the counter per
// active line, inserts horizontal/vertical blanking, reports frame
// completion and trips a watchdog when end_line never arrives.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of line_scan_sequencer_if (all outputs registered)
module line_scan_sequencer
  import line_seq_pkg::*;
#(
  parameter int unsigned ACTIVE_LINES = DEF_ACTIVE_LINES,
  parameter int unsigned HBLANK_CYC   = DEF_HBLANK_CYC,
  parameter int unsigned VBLANK_CYC   = DEF_VBLANK_CYC,
  parameter int unsigned MAX_LINE_CYC = DEF_MAX_LINE_CYC,
  parameter int unsigned CONTINUOUS   = DEF_CONTINUOUS
) (
  input  logic                  clk,
  input  logic                  rst,
  line_scan_sequencer_if.slave  bus
);

  localparam int unsigned TMR_W = timer_width(HBLANK_CYC, VBLANK_CYC, MAX_LINE_CYC);

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(ACTIVE_LINES - 32'd1);
  localparam logic [TMR_W-1:0]  HB_LIM    = TMR_W'(HBLANK_CYC - 32'd1);
  localparam logic [TMR_W-1:0]  VB_LIM    = TMR_W'(VBLANK_CYC - 32'd1);
  localparam logic [TMR_W-1:0]  WD_LIM    = TMR_W'(MAX_LINE_CYC - 32'd1);
  // Count one before the last VBLANK cycle, so frame_done lands on the last one.
  localparam logic [TMR_W-1:0]  VB_PRE    =
    TMR_W'((VBLANK_CYC >= 32'd2) ? (VBLANK_CYC - 32'd2) : 32'd0);
  localparam bit                VB_ONE    = (VBLANK_CYC == 32'd1);
  localparam bit                ONE_SHOT  = (CONTINUOUS == 32'd0);

  seq_state_e        state_q, state_d;
  logic              cnt_enb_q, cnt_enb_d;
  logic              cnt_test_q, cnt_test_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic              hblank_q, hblank_d;
  logic              vblank_q, vblank_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              stop_pend_q, stop_pend_d;

  logic              tmr_clr, tmr_en;
  logic [TMR_W-1:0]  tmr_limit, tmr_cnt;
  logic              tmr_at_limit;

  // One timer serves all intervals; the FSM picks the limit per state.
  seq_timer #(.W(TMR_W)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (tmr_clr),
    .load_i       (1'b0),
    .load_val_i   ({TMR_W{1'b0}}),
    .en_i         (tmr_en),
    .limit_i      (tmr_limit),
    .cnt_o        (tmr_cnt),
    .at_limit_c_o (tmr_at_limit)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_enb_d    = 1'b0;
    cnt_test_d   = cnt_test_q;
    line_idx_d   = line_idx_q;
    hblank_d     = 1'b0;
    vblank_d     = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    stop_pend_d  = stop_pend_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    tmr_limit    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_ACTIVE;
          cnt_test_d  = bus.test_mode;
          line_idx_d  = '0;
          err_d       = 1'b0;
          stop_pend_d = bus.stop;
          tmr_clr     = 1'b1;
          cnt_enb_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_ACTIVE: begin
        tmr_limit = WD_LIM;
        tmr_en    = 1'b1;
        if (bus.stop) stop_pend_d = 1'b1;
        // end_line takes priority over a coincident watchdog expiry.
        if (bus.end_line) begin
          tmr_clr = 1'b1;
          busy_d  = 1'b1;
          if (line_idx_q == LAST_LINE) begin
            state_d      = ST_VBLANK;
            vblank_d     = 1'b1;
            frame_done_d = VB_ONE;
          end else begin
            state_d  = ST_HBLANK;
            hblank_d = 1'b1;
          end
        end else if (tmr_at_limit) begin
          state_d     = ST_IDLE;
          err_d       = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          cnt_enb_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_HBLANK: begin
        tmr_limit = HB_LIM;
        tmr_en    = 1'b1;
        busy_d    = 1'b1;
        if (bus.stop) stop_pend_d = 1'b1;
        if (tmr_at_limit) begin
          state_d    = ST_ACTIVE;
          line_idx_d = line_idx_q + LINE_W'(1);
          tmr_clr    = 1'b1;
          cnt_enb_d  = 1'b1;
        end else begin
          hblank_d = 1'b1;
        end
      end

      ST_VBLANK: begin
        tmr_limit = VB_LIM;
        tmr_en    = 1'b1;
        if (bus.stop) stop_pend_d = 1'b1;
        if (tmr_at_limit) begin
          // A stop seen in the final cycle still ends the run here.
          if (stop_pend_q || bus.stop || ONE_SHOT) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            state_d    = ST_ACTIVE;
            line_idx_d = '0;
            cnt_test_d = bus.test_mode;
            tmr_clr    = 1'b1;
            cnt_enb_d  = 1'b1;
            busy_d     = 1'b1;
          end
        end else begin
          vblank_d     = 1'b1;
          busy_d       = 1'b1;
          frame_done_d = !VB_ONE && (tmr_cnt == VB_PRE);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_enb_q    <= 1'b0;
      cnt_test_q   <= 1'b0;
      line_idx_q   <= '0;
      hblank_q     <= 1'b0;
      vblank_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_enb_q    <= cnt_enb_d;
      cnt_test_q   <= cnt_test_d;
      line_idx_q   <= line_idx_d;
      hblank_q     <= hblank_d;
      vblank_q     <= vblank_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign bus.cnt_enb    = cnt_enb_q;
  assign bus.cnt_test   = cnt_test_q;
  assign bus.line_idx   = line_idx_q;
  assign bus.hblank     = hblank_q;
  assign bus.vblank     = vblank_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Bench for line_scan_sequencer: a one-shot and a continuous instance share
// start/stop/test_mode; each has its own line-counter model on end_line.
// Expected outputs come from a frame-position model (arithmetic on the
// cycle offset since frame start).
module tb_line_scan_sequencer;
  import line_seq_pkg::*;

  localparam int unsigned AL = 3;
  localparam int unsigned HB = 2;
  localparam int unsigned VB = 4;
  localparam int unsigned WD = 20;
  localparam int          OW = LINE_W + 7;

  typedef logic [OW-1:0] obs_t;  // {enb,test,line,hb,vb,busy,fd,err}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_scan_sequencer_if if_s ();
  line_scan_sequencer_if if_c ();

  line_scan_sequencer #(
    .ACTIVE_LINES(AL), .HBLANK_CYC(HB), .VBLANK_CYC(VB),
    .MAX_LINE_CYC(WD), .CONTINUOUS(0)
  ) u_dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));

  line_scan_sequencer #(
    .ACTIVE_LINES(AL), .HBLANK_CYC(HB), .VBLANK_CYC(VB),
    .MAX_LINE_CYC(WD), .CONTINUOUS(1)
  ) u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  int   total = 0;
  int   bad   = 0;

  // Reference model state per instance (0 = one-shot, 1 = continuous).
  bit   m_run  [2];
  int   m_p    [2];
  int   m_L    [2];
  bit   m_tm   [2];
  bit   m_stop [2];
  bit   m_err  [2];
  int   m_hold [2];

  int   lat     [2];   // counter latency; 0 = never ends the line
  int   env_run [2];
  bit   noise_en;
  int   fd_cnt   [2];
  int   busy_cnt [2];
  int   tst_cnt  [2];
  int   max_line [2];
  obs_t last_obs [2];

  function automatic obs_t obs_of(input int i);
    if (i == 0)
      return {if_s.cnt_enb, if_s.cnt_test, if_s.line_idx, if_s.hblank,
              if_s.vblank, if_s.busy, if_s.frame_done, if_s.err};
    return {if_c.cnt_enb, if_c.cnt_test, if_c.line_idx, if_c.hblank,
            if_c.vblank, if_c.busy, if_c.frame_done, if_c.err};
  endfunction

  function automatic bit lat_ok(input int l);
    return (l >= 1) && (l <= int'(WD));
  endfunction

  // Busy cycles of one frame (or of a watchdog abort).
  function automatic int frame_len(input int l);
    if (!lat_ok(l)) return int'(WD);
    return int'(AL) * l + int'(AL - 1) * int'(HB) + int'(VB);
  endfunction

  function automatic obs_t exp_of(input int i);
    int   p, l, per, act_end, line;
    logic enb, hb, vb, fd;
    if (!m_run[i])
      return {1'b0, m_tm[i], LINE_W'(m_hold[i]), 4'b0000, m_err[i]};
    p = m_p[i]; l = m_L[i];
    enb = 1'b0; hb = 1'b0; vb = 1'b0; fd = 1'b0; line = 0;
    if (!lat_ok(l)) begin
      enb = 1'b1;
    end else begin
      per     = l + int'(HB);
      act_end = int'(AL) * l + int'(AL - 1) * int'(HB);
      if (p < act_end) begin
        line = p / per;
        enb  = (p % per) < l;
        hb   = !enb;
      end else begin
        line = int'(AL) - 1;
        vb   = 1'b1;
        fd   = (p == act_end + int'(VB) - 1);
      end
    end
    return {enb, m_tm[i], LINE_W'(line), hb, vb, 1'b1, fd, m_err[i]};
  endfunction

  function automatic void model_edge(input int i, input bit st, input bit sp, input bit tm);
    if (!m_run[i]) begin
      if (st) begin
        m_run[i] = 1'b1; m_p[i] = 0; m_L[i] = lat[i]; m_tm[i] = tm;
        m_err[i] = 1'b0; m_stop[i] = sp; m_hold[i] = 0;
      end
    end else begin
      if (sp) m_stop[i] = 1'b1;
      if (m_p[i] == frame_len(m_L[i]) - 1) begin
        if (!lat_ok(m_L[i])) begin
          m_run[i] = 1'b0; m_err[i] = 1'b1; m_stop[i] = 1'b0; m_hold[i] = 0;
        end else if (i == 0 || m_stop[i]) begin
          m_run[i] = 1'b0; m_stop[i] = 1'b0; m_hold[i] = int'(AL) - 1;
        end else begin
          m_p[i] = 0; m_tm[i] = tm; m_L[i] = lat[i];
        end
      end else begin
        m_p[i] = m_p[i] + 1;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0; m_p[i] = 0; m_L[i] = 0; m_tm[i] = 1'b0;
      m_stop[i] = 1'b0; m_err[i] = 1'b0; m_hold[i] = 0; env_run[i] = 0;
    end
  endfunction

  function automatic void clear_stats();
    for (int i = 0; i < 2; i++) begin
      fd_cnt[i] = 0; busy_cnt[i] = 0; tst_cnt[i] = 0; max_line[i] = 0;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    obs_t o, e;
    for (int i = 0; i < 2; i++) begin
      o = obs_of(i);
      e = exp_of(i);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL out_%0d t=%0t observed=%h expected=%h", i, $time, o, e);
      end
      last_obs[i] = o;
      fd_cnt[i]   += int'(o[1]);
      busy_cnt[i] += int'(o[2]);
      tst_cnt[i]  += int'(o[2] & o[OW-2]);
      if (int'(o[OW-3:5]) > max_line[i]) max_line[i] = int'(o[OW-3:5]);
    end
  endtask

  // One clock: check at negedge, drive inputs, advance model on posedge.
  task automatic step(input bit st, input bit sp, input bit tm);
    obs_t o;
    logic el [2];
    @(negedge clk);
    check_all();
    for (int i = 0; i < 2; i++) begin
      o = obs_of(i);
      if (o[OW-1]) begin
        env_run[i]++;
        el[i] = (lat[i] != 0) && (env_run[i] == lat[i]);
      end else begin
        env_run[i] = 0;
        el[i] = noise_en;
      end
    end
    if_s.end_line = el[0];  if_c.end_line = el[1];
    if_s.start = st; if_s.stop = sp; if_s.test_mode = tm;
    if_c.start = st; if_c.stop = sp; if_c.test_mode = tm;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, st, sp, tm);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return 25;
    if (r == 2) return int'(WD);
    return int'($urandom_range(1, 12));
  endfunction

  initial begin
    rst = 1'b1;
    if_s.start = 1'b0; if_s.stop = 1'b0; if_s.test_mode = 1'b0; if_s.end_line = 1'b0;
    if_c.start = 1'b0; if_c.stop = 1'b0; if_c.test_mode = 1'b0; if_c.end_line = 1'b0;
    noise_en = 1'b0;
    lat[0] = 10; lat[1] = 10;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_s", int'(obs_of(0)), 0);
    chk("reset_c", int'(obs_of(1)), 0);
    rst = 1'b0;
    idle(2);

    // Single frame; the continuous copy gets start+stop together.
    clear_stats();
    step(1'b1, 1'b1, 1'b0);
    idle(50);
    chk("single_fd_s", fd_cnt[0], 1);
    chk("single_len_s", busy_cnt[0], frame_len(10));
    chk("single_maxline_s", max_line[0], int'(AL) - 1);
    chk("startstop_fd_c", fd_cnt[1], 1);
    chk("startstop_len_c", busy_cnt[1], frame_len(10));

    // test_mode latched at start, toggled every cycle afterwards.
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, k[0]);
    chk("test_latch_s", tst_cnt[0], frame_len(10));
    chk("test_latch_c", tst_cnt[1], frame_len(10));

    // Continuous frame, stop during line 1.
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    idle(14);
    step(1'b0, 1'b1, 1'b0);
    idle(50);
    chk("stop_line1_fd_c", fd_cnt[1], 1);
    chk("stop_line1_len_c", busy_cnt[1], frame_len(10));
    chk("stop_line1_busy_c", int'(last_obs[1][2]), 0);

    // Two continuous frames, stop during the second.
    clear_stats();
    step(1'b1, 1'b0, 1'b1);
    idle(50);
    step(1'b0, 1'b1, 1'b0);
    idle(60);
    chk("two_frames_fd_c", fd_cnt[1], 2);
    chk("two_frames_len_c", busy_cnt[1], 2 * frame_len(10));
    chk("two_frames_fd_s", fd_cnt[0], 1);

    // Watchdog: counter never ends the line.
    lat[0] = 0; lat[1] = 0;
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    idle(30);
    chk("wd_err_s", int'(last_obs[0][0]), 1);
    chk("wd_err_c", int'(last_obs[1][0]), 1);
    chk("wd_len_s", busy_cnt[0], int'(WD));
    chk("wd_fd_s", fd_cnt[0], 0);
    lat[0] = 10; lat[1] = 10;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("wd_clear_s", int'(last_obs[0][0]), 0);
    chk("wd_clear_c", int'(last_obs[1][0]), 0);
    idle(50);

    // end_line on the watchdog's last cycle wins.
    lat[0] = int'(WD); lat[1] = int'(WD);
    clear_stats();
    step(1'b1, 1'b1, 1'b0);
    idle(80);
    chk("wd_edge_err_s", int'(last_obs[0][0]), 0);
    chk("wd_edge_fd_s", fd_cnt[0], 1);
    chk("wd_edge_len_s", busy_cnt[0], frame_len(int'(WD)));

    // start during HBLANK ignored; end_line held high outside ACTIVE.
    lat[0] = 10; lat[1] = 10;
    noise_en = 1'b1;
    clear_stats();
    step(1'b1, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b0);
    idle(50);
    chk("hb_start_fd_s", fd_cnt[0], 1);
    chk("hb_start_len_s", busy_cnt[0], frame_len(10));
    chk("vb_endline_len_c", busy_cnt[1], frame_len(10));
    noise_en = 1'b0;

    // Asynchronous reset in the middle of HBLANK.
    step(1'b1, 1'b1, 1'b1);
    idle(11);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_s", int'(obs_of(0)), 0);
    chk("rst_async_c", int'(obs_of(1)), 0);
    model_reset();
    if_s.end_line = 1'b0; if_c.end_line = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    idle(3);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) if (!m_run[i]) lat[i] = pick_lat();
      noise_en = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
           1'($urandom_range(0, 1)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
